// File: rtl/clause_bound_collector_pkg.sv
// Shared definitions for the clause bound collector family.
//
// Contents:
//   state_e        - collector state encoding (IDLE / COLLECT / DONE)
//   DEFAULT_*      - default coefficient and clause-count widths
//   bound_w()      - width of a bound register for a given coefficient width
//   domain_min()   - most negative value of a W-bit signed coefficient
//   domain_max()   - most positive value of a W-bit signed coefficient
package clause_bound_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int DEFAULT_COEF_W  = 8;
  localparam int DEFAULT_COUNT_W = 4;

  // One extra bit lets -b be represented for b = -2^(W-1).
  function automatic int bound_w(input int coef_w);
    return coef_w + 1;
  endfunction

  function automatic int domain_min(input int coef_w);
    return -(1 << (coef_w - 1));
  endfunction

  function automatic int domain_max(input int coef_w);
    return (1 << (coef_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/clause_bound_update.sv
// Combinational fold of one reduced clause into a feasible interval.
//
// Ports:
//   lower_i, upper_i  current bounds (W+1 signed)
//   infeasible_i      current sticky infeasible flag
//   bias_i            clause bias b (W signed)
//   sign_i            1: +y <= b (tightens upper), 0: -y <= b (tightens lower)
//   active_i          0: clause does not involve the variable, bounds pass through
//   lower_o, upper_o  bounds after applying the clause
//   infeasible_o      sticky flag recomputed from the updated bounds
module clause_bound_update
  import clause_bound_collector_pkg::*;
#(
  parameter int W = DEFAULT_COEF_W
) (
  input  logic signed [W:0]   lower_i,
  input  logic signed [W:0]   upper_i,
  input  logic                infeasible_i,
  input  logic signed [W-1:0] bias_i,
  input  logic                sign_i,
  input  logic                active_i,
  output logic signed [W:0]   lower_o,
  output logic signed [W:0]   upper_o,
  output logic                infeasible_o
);

  logic signed [W:0] bias_ext;
  logic signed [W:0] bias_neg;

  always_comb begin
    // Sign-extend first so the negation of -2^(W-1) lands on +2^(W-1).
    bias_ext = {bias_i[W-1], bias_i};
    bias_neg = -bias_ext;

    lower_o = lower_i;
    upper_o = upper_i;
    if (active_i) begin
      if (sign_i) begin
        if (bias_ext < upper_i) begin
          upper_o = bias_ext;
        end
      end else begin
        if (bias_neg > lower_i) begin
          lower_o = bias_neg;
        end
      end
    end

    infeasible_o = infeasible_i | (lower_o > upper_o);
  end

endmodule

// File: rtl/clause_bound_collector.sv
// Consumer end of the reduced-clause stream for one variable. Folds a pass of
// clauses (+/-)y <= b into an interval lower <= y <= upper and flags an empty
// interval.
//
// Ports:
//   in_clk, in_reset_n   clock (rising edge) and asynchronous active-low reset
//   in_start             one-cycle pulse: abort any pass and begin a new one
//   in_clause_valid      clause beat present
//   in_bias, in_sign     clause b and direction (1: +y <= b, 0: -y <= b)
//   in_active            clause involves this variable
//   in_last              final beat of the pass
//   out_ready            beats are accepted (COLLECT)
//   out_lower, out_upper current/final bounds (W+1 signed)
//   out_infeasible       lower > upper seen during this pass (sticky)
//   out_active_count     active clauses applied, saturating
//   out_done             result valid, held until the next in_start
module clause_bound_collector
  import clause_bound_collector_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT  = DEFAULT_COEF_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT = DEFAULT_COUNT_W
) (
  input  logic                                               in_clk,
  input  logic                                               in_reset_n,
  input  logic                                               in_start,
  input  logic                                               in_clause_valid,
  input  logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_bias,
  input  logic                                               in_sign,
  input  logic                                               in_active,
  input  logic                                               in_last,
  output logic                                               out_ready,
  output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT:0]   out_lower,
  output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT:0]   out_upper,
  output logic                                               out_infeasible,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT-1:0]       out_active_count,
  output logic                                               out_done
);

  localparam int W  = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
  localparam int N  = MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT;
  localparam int BW = bound_w(W);

  localparam logic signed [BW-1:0] LOWER_LIMIT = BW'(domain_min(W));
  localparam logic signed [BW-1:0] UPPER_LIMIT = BW'(domain_max(W));
  localparam logic [N-1:0]         COUNT_MAX   = '1;

  state_e               state_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 infeasible_q;
  logic signed [BW-1:0] lower_q;
  logic signed [BW-1:0] upper_q;
  logic [N-1:0]         count_q;

  logic signed [BW-1:0] lower_d;
  logic signed [BW-1:0] upper_d;
  logic                 infeasible_d;
  logic [N-1:0]         count_d;
  logic                 accept;

  clause_bound_update #(
    .W(W)
  ) u_update (
    .lower_i      (lower_q),
    .upper_i      (upper_q),
    .infeasible_i (infeasible_q),
    .bias_i       (in_bias),
    .sign_i       (in_sign),
    .active_i     (in_active),
    .lower_o      (lower_d),
    .upper_o      (upper_d),
    .infeasible_o (infeasible_d)
  );

  // A start pulse wins over a beat in the same cycle; that beat is dropped.
  assign accept = (state_q == ST_COLLECT) && in_clause_valid && !in_start;

  always_comb begin
    count_d = count_q;
    if (in_active && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      infeasible_q <= 1'b0;
      lower_q      <= LOWER_LIMIT;
      upper_q      <= UPPER_LIMIT;
      count_q      <= '0;
    end else if (in_start) begin
      state_q      <= ST_COLLECT;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      infeasible_q <= 1'b0;
      lower_q      <= LOWER_LIMIT;
      upper_q      <= UPPER_LIMIT;
      count_q      <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            lower_q      <= lower_d;
            upper_q      <= upper_d;
            infeasible_q <= infeasible_d;
            count_q      <= count_d;
            if (in_last) begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          // Beats outside a pass are ignored.
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_ready        = ready_q;
  assign out_done         = done_q;
  assign out_infeasible   = infeasible_q;
  assign out_lower        = lower_q;
  assign out_upper        = upper_q;
  assign out_active_count = count_q;

endmodule

// File: tb/tb_clause_bound_collector.sv
module tb_clause_bound_collector;

  logic              in_clk;
  logic              in_reset_n;
  logic              in_start;
  logic              in_clause_valid;
  logic signed [7:0] in_bias;
  logic              in_sign;
  logic              in_active;
  logic              in_last;
  logic              out_ready;
  logic signed [8:0] out_lower;
  logic signed [8:0] out_upper;
  logic              out_infeasible;
  logic [3:0]        out_active_count;
  logic              out_done;

  int compared   = 0;
  int mismatched = 0;

  clause_bound_collector #(
    .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT  (8),
    .MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT (4)
  ) dut (
    .in_clk           (in_clk),
    .in_reset_n       (in_reset_n),
    .in_start         (in_start),
    .in_clause_valid  (in_clause_valid),
    .in_bias          (in_bias),
    .in_sign          (in_sign),
    .in_active        (in_active),
    .in_last          (in_last),
    .out_ready        (out_ready),
    .out_lower        (out_lower),
    .out_upper        (out_upper),
    .out_infeasible   (out_infeasible),
    .out_active_count (out_active_count),
    .out_done         (out_done)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs starting at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic start, input logic valid, input logic sign,
                       input int bias, input logic active, input logic last);
    in_start        = start;
    in_clause_valid = valid;
    in_sign         = sign;
    in_bias         = 8'(bias);
    in_active       = active;
    in_last         = last;
    @(posedge in_clk);
    #1;
    in_start        = 1'b0;
    in_clause_valid = 1'b0;
    in_last         = 1'b0;
    $display("beat start=%0b valid=%0b sign=%0b bias=%0d act=%0b last=%0b -> lo=%0d up=%0d cnt=%0d inf=%0b done=%0b rdy=%0b",
             start, valid, sign, bias, active, last, out_lower, out_upper,
             out_active_count, out_infeasible, out_done, out_ready);
  endtask

  initial begin
    in_reset_n = 1'b0;
    in_start = 0; in_clause_valid = 0; in_bias = 0; in_sign = 0; in_active = 0; in_last = 0;
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    check("rst_ready", out_ready, 0);
    check("rst_done", out_done, 0);
    check("rst_inf", out_infeasible, 0);
    check("rst_count", out_active_count, 0);
    check("rst_lower", out_lower, -128);
    check("rst_upper", out_upper, 127);
    in_reset_n = 1'b1;

    // Pass 1: simple tightening.
    cycle(1, 0, 0, 0, 0, 0);
    check("p1_ready", out_ready, 1);
    check("p1_done0", out_done, 0);
    cycle(0, 1, 1, 5, 1, 0);
    check("p1_up_b1", out_upper, 5);
    check("p1_cnt_b1", out_active_count, 1);
    cycle(0, 1, 0, 3, 1, 0);
    check("p1_lo_b2", out_lower, -3);
    cycle(0, 0, 1, 1, 1, 0); // idle gap inside COLLECT
    check("p1_gap_up", out_upper, 5);
    check("p1_gap_cnt", out_active_count, 2);
    cycle(0, 1, 1, 2, 1, 1);
    check("p1_lower", out_lower, -3);
    check("p1_upper", out_upper, 2);
    check("p1_count", out_active_count, 3);
    check("p1_inf", out_infeasible, 0);
    check("p1_done", out_done, 1);
    check("p1_ready_off", out_ready, 0);

    // Pass 2: infeasible interval, then cleared by start.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, -4, 1, 0);
    check("p2_up_b1", out_upper, -4);
    cycle(0, 1, 0, -1, 1, 1);
    check("p2_lower", out_lower, 1);
    check("p2_upper", out_upper, -4);
    check("p2_inf", out_infeasible, 1);
    check("p2_done", out_done, 1);
    cycle(1, 0, 0, 0, 0, 0);
    check("p2_clr_inf", out_infeasible, 0);
    check("p2_clr_done", out_done, 0);
    check("p2_clr_lo", out_lower, -128);
    check("p2_clr_up", out_upper, 127);
    check("p2_clr_cnt", out_active_count, 0);

    // Pass 3: negation of the most negative bias.
    cycle(0, 1, 0, -128, 1, 1);
    check("p3_lower", out_lower, 128);
    check("p3_upper", out_upper, 127);
    check("p3_inf", out_infeasible, 1);
    check("p3_done", out_done, 1);
    cycle(0, 1, 1, 0, 1, 1); // beat in DONE is ignored
    check("p3_ign_up", out_upper, 127);
    check("p3_ign_cnt", out_active_count, 1);
    check("p3_ign_done", out_done, 1);

    // Pass 4: all inactive beats.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 3, 0, 0);
    check("p4_done_mid", out_done, 0);
    cycle(0, 1, 0, 3, 0, 0);
    cycle(0, 1, 1, -9, 0, 1);
    check("p4_lower", out_lower, -128);
    check("p4_upper", out_upper, 127);
    check("p4_count", out_active_count, 0);
    check("p4_done", out_done, 1);
    check("p4_inf", out_infeasible, 0);

    // Pass 5: restart with a simultaneous beat that must be dropped.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 10, 1, 0);
    check("p5_up_b1", out_upper, 10);
    cycle(1, 1, 1, 1, 1, 0);
    check("p5_restart_up", out_upper, 127);
    check("p5_restart_cnt", out_active_count, 0);
    check("p5_restart_rdy", out_ready, 1);
    cycle(0, 1, 1, 20, 1, 1);
    check("p5_upper", out_upper, 20);
    check("p5_count", out_active_count, 1);
    check("p5_done", out_done, 1);

    // Pass 6: counter saturation at 15 after 17 active beats.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 1, 100, 1, (i == 16) ? 1'b1 : 1'b0);
    end
    check("p6_count_sat", out_active_count, 15);
    check("p6_upper", out_upper, 100);
    check("p6_done", out_done, 1);

    // Pass 7: asynchronous reset mid-collect.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 7, 1, 0);
    check("p7_up_b1", out_upper, 7);
    #3;
    in_reset_n = 1'b0;
    #1;
    check("p7_arst_rdy", out_ready, 0);
    check("p7_arst_up", out_upper, 127);
    check("p7_arst_cnt", out_active_count, 0);
    #2;
    in_reset_n = 1'b1;
    @(posedge in_clk);
    #1;
    cycle(0, 1, 1, 3, 1, 1); // IDLE: ignored
    check("p7_idle_up", out_upper, 127);
    check("p7_idle_done", out_done, 0);
    check("p7_idle_rdy", out_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clause_bound_collector.md
Name: clause_bound_collector

Overview:
- Consumer end of the reduced-clause interface: accepts the stream of reduced clauses (+/-)y <= b for one variable, one clause per beat.
- Folds the stream into a feasible interval lower <= y <= upper for that variable, plus an infeasible flag.
- Sits between the bank of clause reducers and the variable sampler; one clause-list pass per sampling step.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, 8, width W of the incoming signed bias.
- MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT, 4, width of the active-clause counter; saturates at 2^N-1.

Ports:
- in_clk  input  1  general clock, rising edge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_start  input  1  one-cycle pulse; begins a new collection.
- in_clause_valid  input  1  clause beat present this cycle.
- in_bias  input  W signed  b of the reduced clause.
- in_sign  input  1  1: +y <= b; 0: -y <= b.
- in_active  input  1  0: clause does not contain the variable, ignore bounds.
- in_last  input  1  qualifies the final beat of the pass.
- out_ready  output  1  high when a beat is accepted (COLLECT state).
- out_lower  output  W+1 signed  current/final lower bound.
- out_upper  output  W+1 signed  current/final upper bound.
- out_infeasible  output  1  lower > upper.
- out_active_count  output  N  number of active clauses applied.
- out_done  output  1  result valid; held until next in_start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (in_reset_n).
- Reset values: state IDLE, out_ready 0, out_done 0, out_infeasible 0, out_active_count 0. out_lower = -2^(W-1) and out_upper = 2^(W-1)-1, both sign-extended to W+1.
- States:
  - IDLE: on in_start -> COLLECT.
  - COLLECT: out_ready=1. A beat is accepted when in_clause_valid=1. An accepted beat with in_last=1 -> DONE.
  - DONE: out_done=1. On in_start -> COLLECT.
- in_start in any state, including mid-COLLECT: abort the pass. Bounds reset to the domain limits, count=0, out_done=0, infeasible=0, then enter COLLECT next cycle. A beat presented in the same cycle as in_start is discarded.
- Accepted beat, in_active=1, in_sign=1: upper <= min(upper, sext(b)).
- Accepted beat, in_active=1, in_sign=0: lower <= max(lower, -sext(b)). Negation is done at W+1 bits, so b = -2^(W-1) yields +2^(W-1) with no overflow.
- Active beats increment the count, saturating at 2^N-1.
- Accepted beat, in_active=0: bounds and count unchanged. in_last is still honoured.
- out_infeasible is registered and recomputed every accepted beat from the updated bounds. It is sticky within a pass and cleared only by in_start or reset.
- Beats while in IDLE or DONE are ignored; no state change.
- Latency:
  - Bounds reflect a beat one cycle after acceptance.
  - out_done rises the cycle after the in_last beat is accepted, together with the final bounds.
- Zero-active pass (all beats inactive): done with the domain limits, count 0, infeasible 0.
- Single-beat pass: a beat with in_last=1 as the first beat is legal.
- Bias semantics are taken as delivered; the upstream truncating division is not corrected here.

Decomposition:
- Shared package: state encoding (IDLE/COLLECT/DONE), the domain-limit constants derived from W, and the W+1 bound width localparam.
- One natural sub-module: clause_bound_update. It is combinational and produces the next lower, next upper and next infeasible from the current bounds and one beat. It is reused by the later multi-variable collector.

Test Plan:
- W=8, reset released, start, beats (+,5,act),(-,3,act),(+,2,act,last) -> one cycle after last: lower=-3, upper=2, count=3, infeasible=0, done=1.
- Start, beats (+,-4,act),(-,-1,act,last) -> lower=1, upper=-4, infeasible=1, done=1. A second start clears infeasible and done.
- Start, beat (-,-128,act,last) -> lower=+128 (9-bit), upper=127, infeasible=1, no overflow wrap.
- Start, three inactive beats with last -> lower=-128, upper=127, count=0, done=1, infeasible=0.
- Start, beat (+,10,act), then in_start again with a simultaneous valid beat (+,1,act) -> that beat is discarded. Subsequent (+,20,act,last) -> upper=20, count=1.
- in_reset_n low mid-COLLECT, asynchronous to the clock edge -> outputs return to reset values immediately. Beats after release are ignored until in_start.
